subtree_rr_scheduler: RTL and testbench



---
 rtl/subtree_rr_scheduler_pkg.sv | 12 +
 rtl/subtree_rr_scheduler_if.sv | 27 ++
 rtl/subtree_rr_scheduler_rr_pick.sv | 35 +++
 rtl/subtree_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_subtree_rr_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/subtree_rr_scheduler_pkg.sv
// rtl/subtree_rr_scheduler_pkg.sv - shared types and helpers for the subtree round-robin scheduler
package sched_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_t;

  localparam int DEFAULT_NUM_CHILD = 5;

  function automatic int wrap_inc(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/subtree_rr_scheduler_if.sv
// rtl/subtree_rr_scheduler_if.sv - request/grant bundle between a parent node and its children
interface subtree_rr_scheduler_if
  import sched_pkg::*;
#(
  parameter int NUM_CHILD = DEFAULT_NUM_CHILD,
  parameter int IDX_W     = $clog2(NUM_CHILD)
);

  logic [NUM_CHILD-1:0] req_i;
  logic [NUM_CHILD-1:0] done_i;
  logic [NUM_CHILD-1:0] gnt_o;
  logic [IDX_W-1:0]     gnt_idx_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic [IDX_W-1:0]     timeout_idx_o;

  modport master (
    input  req_i, done_i,
    output gnt_o, gnt_idx_o, busy_o, timeout_o, timeout_idx_o
  );

  modport slave (
    output req_i, done_i,
    input  gnt_o, gnt_idx_o, busy_o, timeout_o, timeout_idx_o
  );

endinterface

// File: rtl/subtree_rr_scheduler_rr_pick.sv
// rtl/subtree_rr_scheduler_rr_pick.sv - rotating priority encoder: first request at or after ptr, with wrap
module rr_pick #(
  parameter int NUM_CHILD = 5,
  parameter int IDX_W     = $clog2(NUM_CHILD)
) (
  input  logic [NUM_CHILD-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [NUM_CHILD-1:0] onehot,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    int cand;
    logic [IDX_W-1:0] sel;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = 0;
    sel    = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_CHILD) begin
        cand = cand - NUM_CHILD;
      end
      sel = IDX_W'(cand);
      if (!found && req[sel]) begin
        found       = 1'b1;
        onehot[sel] = 1'b1;
        idx         = sel;
      end
    end
  end

endmodule

// File: rtl/subtree_rr_scheduler.sv
// rtl/subtree_rr_scheduler.sv - round-robin grant of a parent-side resource to its child instances
module subtree_rr_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CHILD = DEFAULT_NUM_CHILD,
  parameter int MAX_HOLD  = 16,
  parameter int IDX_W     = $clog2(NUM_CHILD)
) (
  input logic                    clk,
  input logic                    rst,
  subtree_rr_scheduler_if.master bus
);

  localparam int                CNT_W   = $clog2(MAX_HOLD + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CHILD-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     timeout_idx_q, timeout_idx_d;

  logic                 pick_found;
  logic [NUM_CHILD-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 rel_done;
  logic                 rel_drop;
  logic                 wd_expire;

  rr_pick #(
    .NUM_CHILD (NUM_CHILD),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req    (bus.req_i),
    .ptr    (ptr_q),
    .found  (pick_found),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      gnt_idx_q     <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_idx_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      timeout_idx_q <= timeout_idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    busy_d        = busy_q;
    timeout_d     = 1'b0;
    timeout_idx_d = timeout_idx_q;
    rel_done      = bus.done_i[gnt_idx_q];
    rel_drop      = !bus.req_i[gnt_idx_q];
    wd_expire     = (MAX_HOLD != 0) && (cnt_q == WD_LAST);

    case (state_q)
      // GAP is the one dead cycle after a release; the next owner is chosen
      // here so back-to-back grants are separated by exactly that cycle.
      IDLE, GAP: begin
        if (pick_found) begin
          state_d   = GRANT;
          gnt_d     = pick_onehot;
          gnt_idx_d = pick_idx;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rel_done || rel_drop || wd_expire) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = IDX_W'(wrap_inc(int'(gnt_idx_q), NUM_CHILD));
          // A completion in the expiry cycle is a normal finish, not a timeout.
          if (wd_expire && !rel_done) begin
            timeout_d     = 1'b1;
            timeout_idx_d = gnt_idx_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt_o         = gnt_q;
  assign bus.gnt_idx_o     = gnt_idx_q;
  assign bus.busy_o        = busy_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.timeout_idx_o = timeout_idx_q;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// tb/tb_subtree_rr_scheduler.sv - scoreboard bench for subtree_rr_scheduler
module tb_subtree_rr_scheduler;

  localparam int N  = 5;
  localparam int MH = 16;
  localparam int IW = $clog2(N);
  localparam int EV_GNT = 0;
  localparam int EV_REL = 1;
  localparam int EV_TO  = 2;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subtree_rr_scheduler_if #(.NUM_CHILD(N), .IDX_W(IW)) bus ();

  subtree_rr_scheduler #(
    .NUM_CHILD (N),
    .MAX_HOLD  (MH),
    .IDX_W     (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  int   mcyc     = 0;
  int   m_owner  = -1;
  int   m_ptr    = 0;
  int   m_held   = 0;
  bit   m_rst    = 1'b1;
  bit   mon_on   = 1'b0;
  logic [N-1:0] rq;
  logic [N-1:0] dn;
  int   p_tog;
  int   p_done;
  int   roll;

  function automatic void push_ev(int kind, int idx);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = mcyc;
    exp_q.push_back(e);
  endfunction

  function automatic logic [N-1:0] owner_mask();
    if (m_owner < 0) return '0;
    return N'(1 << m_owner);
  endfunction

  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic expect_ev(int kind, int idx);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d idx=%0d cyc=%0d, required no event", kind, idx, mcyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.cyc != mcyc) begin
        failures++;
        $display("FAIL event: got kind=%0d idx=%0d cyc=%0d, required kind=%0d idx=%0d cyc=%0d",
                 kind, idx, mcyc, e.kind, e.idx, e.cyc);
      end
    end
  endtask

  task automatic step(logic [N-1:0] r, logic [N-1:0] d, bit rs);
    bus.req_i  = r;
    bus.done_i = d;
    rst        = rs;
    @(posedge clk);
    #1;
  endtask

  // Reference: one owner at a time, released by done, dropped request or a
  // hold of MH cycles; the next owner is the first requester after the last one.
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    bit hit_done;
    bit hit_drop;
    bit hit_wd;
    forever begin
      @(posedge clk);
      r     = bus.req_i;
      d     = bus.done_i;
      m_rst = rst;
      mcyc++;
      if (rst) begin
        if (m_owner >= 0) push_ev(EV_REL, m_owner);
        m_owner = -1;
        m_ptr   = 0;
      end else if (m_owner >= 0) begin
        m_held++;
        hit_done = d[m_owner];
        hit_drop = !r[m_owner];
        hit_wd   = (m_held >= MH);
        if (hit_done || hit_drop || hit_wd) begin
          push_ev(EV_REL, m_owner);
          if (hit_wd && !hit_done) push_ev(EV_TO, m_owner);
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_held = 0;
        push_ev(EV_GNT, m_owner);
      end
    end
  end

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] g;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        g = bus.gnt_o;
        checks++;
        if (!$onehot0(g)) begin
          failures++;
          $display("FAIL gnt_onehot: got %b, required one-hot or zero", g);
        end
        checks++;
        if (bus.busy_o !== (g != '0)) begin
          failures++;
          $display("FAIL busy_vs_gnt: got busy=%b gnt=%b, required busy=%b", bus.busy_o, g, (g != '0));
        end
        if (prev != '0 && g != prev) expect_ev(EV_REL, idx_of(prev));
        if (prev != '0 && g == '0 && !m_rst) chk("gnt_idx_kept", int'(bus.gnt_idx_o), idx_of(prev));
        if (bus.timeout_o) expect_ev(EV_TO, int'(bus.timeout_idx_o));
        if (g != '0 && g != prev) begin
          expect_ev(EV_GNT, idx_of(g));
          chk("gnt_idx_on_grant", int'(bus.gnt_idx_o), idx_of(g));
        end
        prev = g;
      end
    end
  end

  initial begin
    rq = '0;
    dn = '0;
    repeat (3) step('0, '0, 1'b1);
    chk("rst_gnt", int'(bus.gnt_o), 0);
    chk("rst_gnt_idx", int'(bus.gnt_idx_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_timeout", int'(bus.timeout_o), 0);
    chk("rst_timeout_idx", int'(bus.timeout_idx_o), 0);
    mon_on = 1'b1;

    // single request, done pulse, then pointer must sit just past child 2
    step(5'b00100, '0, 1'b0);
    step(5'b00100, '0, 1'b0);
    step(5'b00100, 5'b00100, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step(5'b01100, '0, 1'b0);
    step(5'b01100, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // all request, each owner finishes on its third grant cycle
    step('0, '0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      step('1, (m_owner >= 0 && m_held == 2) ? owner_mask() : '0, 1'b0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // watchdog on a child that never finishes
    step('0, '0, 1'b1);
    for (int c = 0; c < 20; c++) step(5'b00010, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // owner 3 drops its request while a stray done hits child 0
    step('0, '0, 1'b1);
    step(5'b01000, '0, 1'b0);
    step(5'b01000, '0, 1'b0);
    step(5'b00001, 5'b00001, 1'b0);
    for (int c = 0; c < 3; c++) step(5'b00001, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // done lands in the watchdog expiry cycle
    step('0, '0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      step(5'b00100, (m_owner == 2 && m_held == MH - 1) ? 5'b00100 : 5'b00000, 1'b0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // reset in the middle of a grant to child 4
    step('0, '0, 1'b1);
    for (int c = 0; c < 3; c++) step(5'b10000, '0, 1'b0);
    step('1, '0, 1'b1);
    chk("midrst_gnt", int'(bus.gnt_o), 0);
    chk("midrst_busy", int'(bus.busy_o), 0);
    chk("midrst_gnt_idx", int'(bus.gnt_idx_o), 0);
    step('1, '0, 1'b0);
    chk("midrst_next_gnt", int'(bus.gnt_o), 1);
    step('1, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        p_tog  = ($urandom_range(0, 2) == 0) ? 8 : 1;
        p_done = $urandom_range(0, 2) * 12;
        rq     = N'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < p_tog) rq[i] = ~rq[i];
      end
      roll = $urandom_range(0, 99);
      if (roll < p_done) dn = owner_mask() | N'($urandom);
      else if (roll < p_done + 15) dn = N'($urandom) & ~owner_mask();
      else dn = '0;
      step(rq, dn, $urandom_range(0, 399) == 0);
    end

    for (int c = 0; c < 30; c++) step('0, '0, 1'b0);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
